// File: rtl/accum_alu.sv
// accum_alu -- parametrised accumulator ALU.
//
// Keeps a W-bit accumulator C. Each accepted transaction (op_valid & op_ready
// at a rising clk edge) applies a 4-bit opcode with operand A. Most ops finish
// at the accepting edge. MUL (shift-add) and DIV (restoring) use W iterations,
// one per clock. During that time op_ready is low and C / C_hi hold the
// iteration state.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   op_valid  opcode/operand presented
//   op_ready  block can accept an op this cycle (IDLE)
//   opcode    operation select
//   A         operand
//   C         accumulator (low result)
//   C_hi      MUL high half / DIV remainder
//   done      one-cycle pulse after an op completes
//   carry     carry / borrow / shifted-out bit
//   overflow  signed overflow, or MUL high half non-zero
//   zero      C == 0
//   error     sticky: undefined opcode or divide by zero
module accum_alu #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] A,
  output logic [W-1:0] C,
  output logic [W-1:0] C_hi,
  output logic         done,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         error
);

  localparam logic [3:0] OP_NOOP = 4'd0,  OP_RST = 4'd1,  OP_LOAD = 4'd2,
                         OP_ADD  = 4'd5,  OP_SUB = 4'd6,  OP_AND  = 4'd9,
                         OP_OR   = 4'd10, OP_XOR = 4'd11, OP_SHL  = 4'd12,
                         OP_SHR  = 4'd13, OP_MUL = 4'd14, OP_DIV  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  b_q;       // operand captured at acceptance

  logic accept, go_mul, go_div, last_iter;

  assign accept    = op_valid & op_ready;
  assign go_mul    = (opcode == OP_MUL);
  assign go_div    = (opcode == OP_DIV) & (A != '0);
  assign last_iter = (cnt_q == CW'(W-1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (go_mul)      state_d = S_MUL;
        else if (go_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    op_ready = (state_q == S_IDLE);
  end

  assign zero = (C == '0);

  // ---------------- single-cycle arithmetic ----------------
  logic [W:0]   add_full;
  logic [W-1:0] sub_res;
  logic         add_ovf, sub_ovf;

  assign add_full = {1'b0, C} + {1'b0, A};
  assign sub_res  = C - A;
  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
  // result sign differs from C.
  assign add_ovf  = (C[W-1] == A[W-1]) & (add_full[W-1] ^ C[W-1]);
  assign sub_ovf  = (C[W-1] ^ A[W-1])  & (sub_res[W-1]  ^ C[W-1]);

  // ---------------- MUL iteration ----------------
  // {C_hi,C} is the product/multiplier pair. Each step adds the multiplicand
  // into the high half when the multiplier LSB is set, then shifts the whole
  // pair (including the add carry) right by one.
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi, mul_lo;

  assign mul_sum = {1'b0, C_hi} + (C[0] ? {1'b0, b_q} : '0);
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], C[W-1:1]};

  // ---------------- DIV iteration ----------------
  // C_hi is the partial remainder and C shifts the dividend out and the
  // quotient in. The shifted remainder needs W+1 bits before the compare.
  logic [W:0]   div_tmp, div_sub;
  logic         div_ge;
  logic [W-1:0] div_hi, div_lo;

  assign div_tmp = {C_hi, C[W-1]};
  assign div_sub = div_tmp - {1'b0, b_q};
  assign div_ge  = (div_tmp >= {1'b0, b_q});
  assign div_hi  = div_ge ? div_sub[W-1:0] : div_tmp[W-1:0];
  assign div_lo  = {C[W-2:0], div_ge};

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C        <= '0;
      C_hi     <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          cnt_q <= '0;
          // MUL and DIV (non-zero divisor) report done only after the iterations.
          done  <= ~(go_mul | go_div);
          case (opcode)
            OP_NOOP: ;
            OP_RST: begin
              C        <= '0;
              C_hi     <= '0;
              carry    <= 1'b0;
              overflow <= 1'b0;
              error    <= 1'b0;
            end
            OP_LOAD: C <= A;
            OP_ADD: begin
              C        <= add_full[W-1:0];
              carry    <= add_full[W];
              overflow <= add_ovf;
            end
            OP_SUB: begin
              C        <= sub_res;
              carry    <= (C < A);
              overflow <= sub_ovf;
            end
            OP_AND: C <= C & A;
            OP_OR:  C <= C | A;
            OP_XOR: C <= C ^ A;
            OP_SHL: begin
              C     <= {C[W-2:0], 1'b0};
              carry <= C[W-1];
            end
            OP_SHR: begin
              C     <= {1'b0, C[W-1:1]};
              carry <= C[0];
            end
            OP_MUL: begin
              C_hi <= '0;
              b_q  <= A;
            end
            OP_DIV: begin
              if (A == '0) begin
                error <= 1'b1;
              end else begin
                C_hi <= '0;
                b_q  <= A;
              end
            end
            default: error <= 1'b1;  // undefined opcodes act as NOOP
          endcase
        end
        S_MUL: begin
          C     <= mul_lo;
          C_hi  <= mul_hi;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            cnt_q    <= '0;
            overflow <= |mul_hi;
            carry    <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_DIV: begin
          C     <= div_lo;
          C_hi  <= div_hi;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            cnt_q    <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
module tb_accum_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   opcode;
  logic [W-1:0] A;
  logic [W-1:0] C, C_hi;
  logic         done, carry, overflow, zero, error;

  int checks   = 0;
  int failures = 0;

  accum_alu #(.W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .A(A), .C(C), .C_hi(C_hi), .done(done),
    .carry(carry), .overflow(overflow), .zero(zero), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents one op at a negedge and waits for its done pulse. It returns
  // the number of sampled cycles before done and the number of those
  // cycles in which op_ready was high. A is scrambled after acceptance.
  task automatic apply(input logic [3:0] op, input logic [W-1:0] a,
                       output int busy, output int rdy_bad);
    @(negedge clk);
    opcode = op; A = a; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; A = W'($urandom); opcode = 4'($urandom);
    busy = 0; rdy_bad = 0;
    @(negedge clk);
    while (!done && busy < W + 4) begin
      if (op_ready) rdy_bad++;
      busy++;
      @(negedge clk);
    end
    if (!done) begin
      failures++; checks++;
      $display("FAIL timeout: op %0d no done after %0d cycles", op, busy);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_c, m_hi;
  logic         m_cy, m_ov, m_er;

  function automatic logic ovf_of(input int v);
    return (v > (2**(W-1) - 1)) || (v < -(2**(W-1)));
  endfunction

  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a);
    int sc, sa;
    longint s;
    logic [2*W-1:0] p;
    logic [W-1:0] q, r;
    sc = $signed(m_c); sa = $signed(a);
    case (op)
      4'd0: ;
      4'd1: begin m_c = 0; m_hi = 0; m_cy = 0; m_ov = 0; m_er = 0; end
      4'd2: m_c = a;
      4'd5: begin
        s = longint'(m_c) + longint'(a);
        m_cy = (s >= (64'd1 << W)); m_ov = ovf_of(sc + sa); m_c = s[W-1:0];
      end
      4'd6: begin
        m_cy = (m_c < a); m_ov = ovf_of(sc - sa); m_c = m_c - a;
      end
      4'd9:  m_c = m_c & a;
      4'd10: m_c = m_c | a;
      4'd11: m_c = m_c ^ a;
      4'd12: begin m_cy = m_c[W-1]; m_c = m_c << 1; end
      4'd13: begin m_cy = m_c[0];   m_c = m_c >> 1; end
      4'd14: begin
        p = {{W{1'b0}}, m_c} * {{W{1'b0}}, a};
        m_c = p[W-1:0]; m_hi = p[2*W-1:W]; m_ov = (m_hi != 0); m_cy = 0;
      end
      4'd15: begin
        if (a == 0) m_er = 1;
        else begin
          q = m_c / a; r = m_c % a;
          m_c = q; m_hi = r; m_cy = 0; m_ov = 0;
        end
      end
      default: m_er = 1;
    endcase
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, c, hi;
    logic         cy, ov, er;
    int           busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] c, input logic [W-1:0] hi,
                              input logic cy, input logic ov, input logic er,
                              input int busy);
    vec_t v;
    v.op = op; v.a = a; v.c = c; v.hi = hi; v.cy = cy; v.ov = ov; v.er = er; v.busy = busy;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    int busy, rdy_bad, n;
    string tag;

    vt.push_back(mk(4'd1,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0)); // RESET
    vt.push_back(mk(4'd5,  8'h01, 8'h01, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd5,  8'h01, 8'h02, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd5,  8'h01, 8'h03, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd5,  8'hFF, 8'h02, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(4'd2,  8'h7F, 8'h7F, 8'h00, 1, 0, 0, 0)); // LOAD keeps flags
    vt.push_back(mk(4'd5,  8'h01, 8'h80, 8'h00, 0, 1, 0, 0));
    vt.push_back(mk(4'd6,  8'h81, 8'hFF, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(4'd9,  8'h0F, 8'h0F, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(4'd2,  8'h0C, 8'h0C, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(4'd14, 8'h15, 8'hFC, 8'h00, 0, 0, 0, W));
    vt.push_back(mk(4'd2,  8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd14, 8'hFF, 8'h01, 8'hFE, 0, 1, 0, W));
    vt.push_back(mk(4'd2,  8'd100, 8'd100, 8'hFE, 0, 1, 0, 0));
    vt.push_back(mk(4'd15, 8'd7,  8'd14, 8'd2,  0, 0, 0, W));
    vt.push_back(mk(4'd15, 8'd0,  8'd14, 8'd2,  0, 0, 1, 0)); // divide by zero
    vt.push_back(mk(4'd0,  8'h00, 8'd14, 8'd2,  0, 0, 1, 0)); // error sticky
    vt.push_back(mk(4'd1,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd2,  8'h81, 8'h81, 8'h00, 0, 0, 0, 0));
    vt.push_back(mk(4'd3,  8'h55, 8'h81, 8'h00, 0, 0, 1, 0)); // undefined op
    vt.push_back(mk(4'd12, 8'h00, 8'h02, 8'h00, 1, 0, 1, 0));
    vt.push_back(mk(4'd13, 8'h00, 8'h01, 8'h00, 0, 0, 1, 0));
    vt.push_back(mk(4'd10, 8'hF0, 8'hF1, 8'h00, 0, 0, 1, 0));
    vt.push_back(mk(4'd11, 8'hF1, 8'h00, 8'h00, 0, 0, 1, 0)); // zero flag

    rst = 1'b0; op_valid = 1'b0; opcode = '0; A = '0;
    #12;
    chk("rst_C", C, 0);   chk("rst_Chi", C_hi, 0); chk("rst_done", done, 0);
    chk("rst_zero", zero, 1); chk("rst_err", error, 0);
    chk("rst_flags", {carry, overflow}, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_ready", op_ready, 1);

    // ---- table phase ----
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].op, vt[i].a, busy, rdy_bad);
      tag = $sformatf("vec%0d", i);
      chk({tag, "_C"},    C,        vt[i].c);
      chk({tag, "_Chi"},  C_hi,     vt[i].hi);
      chk({tag, "_cy"},   carry,    vt[i].cy);
      chk({tag, "_ov"},   overflow, vt[i].ov);
      chk({tag, "_err"},  error,    vt[i].er);
      chk({tag, "_zero"}, zero,     (vt[i].c == 0));
      chk({tag, "_busy"}, busy,     vt[i].busy);
      chk({tag, "_rdy"},  rdy_bad,  0);
    end

    // ---- MUL with an ADD held on the input while busy ----
    apply(4'd2, 8'h0C, busy, rdy_bad);
    @(negedge clk);
    opcode = 4'd14; A = 8'h15; op_valid = 1'b1;
    @(posedge clk);
    #1 opcode = 4'd5; A = 8'h33;
    n = 0;
    @(negedge clk);
    while (!done && n < W + 4) begin n++; @(negedge clk); end
    op_valid = 1'b0;
    chk("hold_busy", n, W);
    chk("hold_C", C, 8'hFC);
    chk("hold_Chi", C_hi, 8'h00);
    @(negedge clk);
    chk("hold_done_pulse", done, 0);
    chk("hold_C_after", C, 8'hFC);

    // ---- asynchronous reset in the middle of a MUL ----
    apply(4'd2, 8'hFF, busy, rdy_bad);
    apply(4'd5, 8'h01, busy, rdy_bad);   // carry=1, C=0
    apply(4'd2, 8'hFF, busy, rdy_bad);
    apply(4'd4, 8'h00, busy, rdy_bad);   // error=1
    @(negedge clk);
    opcode = 4'd14; A = 8'hFF; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", op_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_C", C, 0); chk("mid_Chi", C_hi, 0);
    chk("mid_flags", {carry, overflow, error, done}, 0);
    chk("mid_zero", zero, 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_ready", op_ready, 1);
    repeat (3) @(negedge clk);
    chk("mid_idle", {done, C}, 0);

    // ---- random ops against the model ----
    m_c = 0; m_hi = 0; m_cy = 0; m_ov = 0; m_er = 0;
    for (int i = 0; i < 250; i++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      int           ebusy;
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      ebusy = (rop == 4'd14 || (rop == 4'd15 && ra != 0)) ? W : 0;
      model_op(rop, ra);
      apply(rop, ra, busy, rdy_bad);
      tag = $sformatf("rnd%0d_op%0d", i, rop);
      chk({tag, "_C"},    C,        m_c);
      chk({tag, "_Chi"},  C_hi,     m_hi);
      chk({tag, "_cy"},   carry,    m_cy);
      chk({tag, "_ov"},   overflow, m_ov);
      chk({tag, "_err"},  error,    m_er);
      chk({tag, "_zero"}, zero,     (m_c == 0));
      chk({tag, "_busy"}, busy,     ebusy);
      chk({tag, "_rdy"},  rdy_bad,  0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
